gray_rx: RTL

GRAY_RX -- requirements
Module: gray_rx

---
 rtl/gray_rx.sv | 105 ++++++++++
 1 files changed

// File: rtl/gray_rx.sv
// Gray code receiver: decodes a Gray counter, checks that each accepted sample is a
// single forward step, flags errors, and counts wraps from the top code back to zero.
module gray_rx #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [WIDTH-1:0] GrayIn,
  output logic [WIDTH-1:0] Binary,
  output logic             Valid,
  output logic             Wrap,
  output logic [CNT_W-1:0] WrapCount,
  output logic             Locked,
  output logic             Error
);

  typedef enum logic [1:0] {ST_UNLOCKED, ST_LOCKED, ST_ERROR} state_t;

  state_t           state, stateNext;
  logic [WIDTH-1:0] storedGray, grayNext, binaryNext;
  logic [WIDTH-1:0] decoded, binaryPlusOne, diff;
  logic             validNext, wrapNext, oneBitChange, legalStep;

  function automatic logic [WIDTH-1:0] grayToBin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign decoded       = grayToBin(GrayIn);
  assign binaryPlusOne = Binary + WIDTH'(1);
  assign diff          = GrayIn ^ storedGray;
  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  assign oneBitChange  = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
  assign legalStep     = oneBitChange && (decoded == binaryPlusOne);

  always_comb begin
    stateNext  = state;
    binaryNext = Binary;
    grayNext   = storedGray;
    validNext  = 1'b0;
    wrapNext   = 1'b0;
    if (En) begin
      case (state)
        ST_UNLOCKED: begin
          stateNext  = ST_LOCKED;
          binaryNext = decoded;
          grayNext   = GrayIn;
          validNext  = 1'b1;
        end
        ST_LOCKED: begin
          if (GrayIn == storedGray) begin
            validNext = 1'b1;
          end else if (legalStep) begin
            binaryNext = decoded;
            grayNext   = GrayIn;
            validNext  = 1'b1;
            wrapNext   = (Binary == '1);
          end else begin
            stateNext = ST_ERROR;
          end
        end
        ST_ERROR: begin
          // Only an all-zero word is trusted enough to resynchronise on.
          if (GrayIn == '0) begin
            stateNext  = ST_LOCKED;
            binaryNext = '0;
            grayNext   = '0;
            validNext  = 1'b1;
          end
        end
        default: stateNext = ST_UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= ST_UNLOCKED;
      Binary     <= '0;
      storedGray <= '0;
      Valid      <= 1'b0;
      Wrap       <= 1'b0;
      WrapCount  <= '0;
    end else begin
      state      <= stateNext;
      Binary     <= binaryNext;
      storedGray <= grayNext;
      Valid      <= validNext;
      Wrap       <= wrapNext;
      if (wrapNext && (WrapCount != '1)) begin
        WrapCount <= WrapCount + CNT_W'(1);
      end
    end
  end

  assign Locked = (state == ST_LOCKED);
  assign Error  = (state == ST_ERROR);

endmodule
